md_counter_updn_mod: RTL

Parametrised synchronous up/down modulo-N counter that succeeds the fixed 4-bit up counter in the counters lab. It adds enable, direction, synchronous load and clear, and three terminal behaviours: wrap, saturate and one-shot. A cascadable terminal-count output lets instances be chained into multi-digit counters, for example BCD stages with MODULUS=10.

---
 rtl/md_counter_pkg.sv | 17 +
 rtl/md_counter_nxt.sv | 39 +++
 rtl/md_counter_updn_mod.sv | 94 +++++++++
 3 files changed

// File: rtl/md_counter_pkg.sv
// Shared constants and parameter legality check for the up/down modulo-N counter.
package md_counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  localparam int unsigned MAX_WIDTH = 32;

  // WIDTH in 1..32 and MODULUS in 2..2^WIDTH.
  function automatic bit params_legal(input int unsigned width,
                                      input longint unsigned modulus);
    return (width >= 1) && (width <= MAX_WIDTH) &&
           (modulus >= 64'd2) && (modulus <= (64'd1 << width));
  endfunction

endpackage

// File: rtl/md_counter_nxt.sv
// Combinational next-count logic: terminal detect, modulo step and terminal action.
module md_counter_nxt
  import md_counter_pkg::*;
#(
  parameter int unsigned      WIDTH   = 4,
  parameter longint unsigned  MODULUS = 16
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             up_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] next_count_o,
  output logic             at_term_o,
  output logic             wrap_evt_o
);

  localparam int unsigned      CW      = WIDTH + 1;
  localparam logic [CW-1:0]    MOD_X   = CW'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 64'd1);

  logic [CW-1:0]    inc_w;
  logic [WIDTH-1:0] inc_mod;
  logic [WIDTH-1:0] dec_mod;
  logic [WIDTH-1:0] step;
  logic             is_wrap;

  // Extra carry bit keeps MODULUS == 2^WIDTH unambiguous.
  assign inc_w   = {1'b0, count_i} + CW'(1);
  assign inc_mod = (inc_w == MOD_X) ? '0 : inc_w[WIDTH-1:0];
  assign dec_mod = (count_i == '0) ? MAX_CNT : (count_i - WIDTH'(1));
  assign step    = up_i ? inc_mod : dec_mod;

  // Reserved mode 2'b11 behaves as WRAP.
  assign is_wrap = (mode_i != MODE_SAT) && (mode_i != MODE_ONESHOT);

  assign at_term_o    = up_i ? (count_i == MAX_CNT) : (count_i == '0);
  assign wrap_evt_o   = at_term_o & is_wrap;
  assign next_count_o = (at_term_o && !is_wrap) ? count_i : step;

endmodule

// File: rtl/md_counter_updn_mod.sv
// Parametrised up/down modulo-N counter with wrap/saturate/one-shot terminal modes
// and a combinational cascade terminal count.
module md_counter_updn_mod
  import md_counter_pkg::*;
#(
  parameter int unsigned      WIDTH   = 4,
  parameter longint unsigned  MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sclr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             done
);

  localparam int unsigned      CW      = WIDTH + 1;
  localparam logic [CW-1:0]    MOD_X   = CW'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 64'd1);

  if (!params_legal(WIDTH, MODULUS)) begin : g_bad_params
    $error("md_counter_updn_mod: illegal WIDTH/MODULUS combination");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] nxt_count;
  logic             at_term;
  logic             wrap_evt;

  md_counter_nxt #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_nxt (
    .count_i      (count_q),
    .up_i         (up),
    .mode_i       (mode),
    .next_count_o (nxt_count),
    .at_term_o    (at_term),
    .wrap_evt_o   (wrap_evt)
  );

  // Priority: sclr > load > en; a completed one-shot ignores en.
  always_comb begin
    count_d = count_q;
    done_d  = done_q;
    wrap_d  = 1'b0;
    if (sclr) begin
      count_d = '0;
      done_d  = 1'b0;
    end else if (load) begin
      count_d = ({1'b0, din} >= MOD_X) ? MAX_CNT : din;
      done_d  = 1'b0;
    end else if (en && !done_q) begin
      count_d = nxt_count;
      wrap_d  = wrap_evt;
      if (at_term && (mode == MODE_ONESHOT)) begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign done  = done_q;
  assign tc    = en & at_term;

`ifndef SYNTHESIS
  a_count_range: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, count_q} < MOD_X));
  a_wrap_idle: assert property (@(posedge clk) disable iff (rst)
    (wrap_q && !en) |=> !wrap_q);
`endif

endmodule
